// File: rtl/logo_pixel_gen.sv
// Moving hollow-square logo generator placed after vga_sync.
// Bounces the logo off the screen edges once per frame and registers RGB with aligned syncs.
module logo_pixel_gen #(
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter int          LOGO_W   = 32,
    parameter int          LOGO_H   = 32,
    parameter int          BORDER   = 4,
    parameter int          STEP     = 2,
    parameter logic [11:0] FG_COLOR = 12'hFF0,
    parameter logic [11:0] BG_COLOR = 12'h00F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        pause,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic [11:0] rgb
);

    localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - LOGO_W);
    localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - LOGO_H);
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [10:0] LW       = 11'(LOGO_W);
    localparam logic [10:0] LH       = 11'(LOGO_H);
    localparam logic [10:0] BW       = 11'(BORDER);
    localparam logic [9:0]  TICK_ROW = 10'(V_ACTIVE + 1);

    logic [9:0]  r_logo_x;
    logic [9:0]  r_logo_y;
    logic        r_dir_x;
    logic        r_dir_y;
    logic [11:0] r_rgb;
    logic        r_hsync;
    logic        r_vsync;

    logic        w_frame_tick;
    logic [10:0] w_lx;
    logic [10:0] w_ly;
    logic [10:0] w_px;
    logic [10:0] w_py;
    logic [10:0] w_x_next;
    logic [10:0] w_y_next;
    logic        w_dir_x_next;
    logic        w_dir_y_next;
    logic        w_in_box;
    logic        w_in_hole;
    logic [11:0] w_rgb;

    // Row V_ACTIVE+1 is inside vertical blanking, so moving here never tears the image.
    assign w_frame_tick = p_tick && (pixel_x == 10'd0) && (pixel_y == TICK_ROW);

    assign w_lx = {1'b0, r_logo_x};
    assign w_ly = {1'b0, r_logo_y};
    assign w_px = {1'b0, pixel_x};
    assign w_py = {1'b0, pixel_y};

    always_comb begin
        w_x_next     = w_lx;
        w_dir_x_next = r_dir_x;
        if (!r_dir_x) begin
            if (w_lx + STEP_W > X_MAX) begin
                w_x_next     = X_MAX;
                w_dir_x_next = 1'b1;
            end else begin
                w_x_next = w_lx + STEP_W;
            end
        end else begin
            if (w_lx < STEP_W) begin
                w_x_next     = 11'd0;
                w_dir_x_next = 1'b0;
            end else begin
                w_x_next = w_lx - STEP_W;
            end
        end
    end

    always_comb begin
        w_y_next     = w_ly;
        w_dir_y_next = r_dir_y;
        if (!r_dir_y) begin
            if (w_ly + STEP_W > Y_MAX) begin
                w_y_next     = Y_MAX;
                w_dir_y_next = 1'b1;
            end else begin
                w_y_next = w_ly + STEP_W;
            end
        end else begin
            if (w_ly < STEP_W) begin
                w_y_next     = 11'd0;
                w_dir_y_next = 1'b0;
            end else begin
                w_y_next = w_ly - STEP_W;
            end
        end
    end

    always_comb begin
        w_in_box  = (w_px >= w_lx) && (w_px < w_lx + LW) &&
                    (w_py >= w_ly) && (w_py < w_ly + LH);
        w_in_hole = (w_px >= w_lx + BW) && (w_px < w_lx + LW - BW) &&
                    (w_py >= w_ly + BW) && (w_py < w_ly + LH - BW);
        w_rgb     = 12'h000;
        if (video_on) begin
            w_rgb = (w_in_box && !w_in_hole) ? FG_COLOR : BG_COLOR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_logo_x <= 10'd0;
            r_logo_y <= 10'd0;
            r_dir_x  <= 1'b0;
            r_dir_y  <= 1'b0;
        end else if (w_frame_tick && !pause) begin
            r_logo_x <= w_x_next[9:0];
            r_logo_y <= w_y_next[9:0];
            r_dir_x  <= w_dir_x_next;
            r_dir_y  <= w_dir_y_next;
        end
    end

    // Colour and syncs share one register stage so they leave the block aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb   <= 12'h000;
            r_hsync <= 1'b0;
            r_vsync <= 1'b0;
        end else if (p_tick) begin
            r_rgb   <= w_rgb;
            r_hsync <= hsync;
            r_vsync <= vsync;
        end
    end

    assign rgb     = r_rgb;
    assign hsync_o = r_hsync;
    assign vsync_o = r_vsync;

endmodule

// File: tb/tb_logo_pixel_gen.sv
// Directed bench for logo_pixel_gen: logo position is inferred from probed pixel colours,
// and expected outputs travel through a scoreboard queue from drive to output.
module tb_logo_pixel_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p_tick = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        pause = 1'b0;
    logic        hsync_o, vsync_o, hsync_o2, vsync_o2;
    logic [11:0] rgb, rgb2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          sel;
        logic [13:0] exp;
        string       tag;
    } sb_t;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    logo_pixel_gen dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync(hsync), .vsync(vsync),
        .pause(pause), .hsync_o(hsync_o), .vsync_o(vsync_o), .rgb(rgb)
    );

    // Small square screen so both axes bounce on the same frame tick.
    logo_pixel_gen #(.H_ACTIVE(64), .V_ACTIVE(64)) dut_sq (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync(hsync), .vsync(vsync),
        .pause(pause), .hsync_o(hsync_o2), .vsync_o(vsync_o2), .rgb(rgb2)
    );

    function automatic logic [11:0] exp_rgb(input int px, input int py,
                                            input int lx, input int ly, input bit von);
        bit box, hole;
        if (!von) return 12'h000;
        box  = px >= lx && px < lx + 32 && py >= ly && py < ly + 32;
        hole = px >= lx + 4 && px < lx + 28 && py >= ly + 4 && py < ly + 28;
        return (box && !hole) ? 12'hFF0 : 12'h00F;
    endfunction

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One pixel slot: inputs held for two clocks, p_tick high on the first when tick=1.
    task automatic drive(input int sel, input int px, input int py, input bit von,
                         input bit hs, input bit vs, input bit ps, input bit tick,
                         input logic [11:0] exp, input string tag);
        sb_t e;
        logic [13:0] obs;
        @(posedge clk); #1;
        pixel_x  = px[9:0];
        pixel_y  = py[9:0];
        video_on = von;
        hsync    = hs;
        vsync    = vs;
        pause    = ps;
        p_tick   = tick;
        if (tick) begin
            e.sel = sel; e.exp = {hs, vs, exp}; e.tag = tag;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        p_tick = 1'b0;
        if (tick) begin
            if (sb_q.size() == 0) begin
                check({tag, "_sbempty"}, 14'h0, 14'h3FFF);
            end else begin
                e   = sb_q.pop_front();
                obs = (e.sel == 1) ? {hsync_o, vsync_o, rgb} : {hsync_o2, vsync_o2, rgb2};
                check(e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic frame_ticks(input int sel, input int n, input bit ps);
        for (int i = 0; i < n; i++)
            drive(sel, 0, (sel == 1) ? 481 : 65, 1'b0, 1'b1, 1'b1, ps, 1'b1, 12'h000, "ftick");
    endtask

    // Pins the logo's top-left corner: its corner pixel is lit, the neighbours left/above are not.
    task automatic probe(input int sel, input int lx, input int ly, input string tag);
        drive(sel, lx, ly, 1, 1, 0, 0, 1, exp_rgb(lx, ly, lx, ly, 1), {tag, "_tl"});
        drive(sel, lx + 31, ly + 31, 1, 0, 1, 0, 1, exp_rgb(lx + 31, ly + 31, lx, ly, 1), {tag, "_br"});
        drive(sel, lx + 4, ly + 4, 1, 0, 0, 0, 1, exp_rgb(lx + 4, ly + 4, lx, ly, 1), {tag, "_hole"});
        drive(sel, lx + 32, ly, 1, 1, 1, 0, 1, exp_rgb(lx + 32, ly, lx, ly, 1), {tag, "_right"});
        if (lx > 0)
            drive(sel, lx - 1, ly, 1, 0, 0, 0, 1, exp_rgb(lx - 1, ly, lx, ly, 1), {tag, "_left"});
        if (ly > 0)
            drive(sel, lx, ly - 1, 1, 1, 0, 0, 1, exp_rgb(lx, ly - 1, lx, ly, 1), {tag, "_above"});
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3;
        reset = 1'b1;
        #3;
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", {hsync_o, vsync_o, rgb}, 14'h0);
        check("reset_out_sq", {hsync_o2, vsync_o2, rgb2}, 14'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Colour lookup with logo at (0,0)
        drive(1, 1, 1, 1, 1, 0, 0, 1, 12'hFF0, "px_1_1");
        drive(1, 10, 10, 1, 0, 1, 0, 1, 12'h00F, "px_10_10");
        drive(1, 40, 5, 1, 1, 1, 0, 1, 12'h00F, "px_40_5");
        drive(1, 1, 1, 0, 0, 1, 0, 1, 12'h000, "px_blank");
        drive(1, 3, 10, 1, 1, 0, 0, 1, 12'hFF0, "px_ring_edge");
        drive(1, 4, 10, 1, 0, 0, 0, 1, 12'h00F, "px_hole_edge");
        drive(1, 31, 31, 1, 0, 0, 0, 1, 12'hFF0, "px_31_31");
        drive(1, 32, 0, 1, 0, 0, 0, 1, 12'h00F, "px_32_0");

        // Outputs hold between p_ticks
        @(posedge clk); #1;
        check("hold", {hsync_o, vsync_o, rgb}, {2'b00, 12'h00F});

        // Asynchronous reset mid-stream clears outputs before any clock edge
        drive(1, 0, 0, 1, 1, 1, 0, 1, 12'hFF0, "pre_reset");
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", {hsync_o, vsync_o, rgb}, 14'h0);
        #2;
        reset = 1'b0;
        frame_ticks(1, 1, 0);
        probe(1, 2, 2, "after_reset_tick");

        // Bottom wall then right wall
        pulse_reset();
        frame_ticks(1, 224, 0);
        probe(1, 448, 448, "t224");
        frame_ticks(1, 1, 0);
        probe(1, 450, 448, "t225_yclamp");
        frame_ticks(1, 1, 0);
        probe(1, 452, 446, "t226_yback");
        frame_ticks(1, 78, 0);
        probe(1, 608, 290, "t304");
        frame_ticks(1, 1, 0);
        probe(1, 608, 288, "t305_xclamp");
        frame_ticks(1, 1, 0);
        probe(1, 606, 286, "t306_xback");

        // Pause freezes the logo
        pulse_reset();
        frame_ticks(1, 50, 0);
        probe(1, 100, 100, "at100");
        frame_ticks(1, 5, 1);
        probe(1, 100, 100, "paused");
        frame_ticks(1, 1, 0);
        probe(1, 102, 102, "unpaused");

        // Near-miss frame ticks
        drive(1, 0, 481, 0, 0, 0, 0, 0, 12'h000, "no_ptick");
        drive(1, 0, 480, 0, 0, 1, 0, 1, 12'h000, "row480");
        drive(1, 1, 481, 0, 1, 0, 0, 1, 12'h000, "col1");
        probe(1, 102, 102, "near_miss");

        // Corner: both axes clamp and reverse together
        pulse_reset();
        frame_ticks(2, 16, 0);
        probe(2, 32, 32, "sq_t16");
        frame_ticks(2, 1, 0);
        probe(2, 32, 32, "sq_corner");
        frame_ticks(2, 1, 0);
        probe(2, 30, 30, "sq_back");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
